// File: rtl/data_memory_pkg.sv
// Shared data-memory types: store-buffer entry layout, store widths and
// the drain FSM state encoding.
package data_memory_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } store_width_t;

    typedef struct packed {
        logic [31:0]  address;
        logic [31:0]  data;
        store_width_t width;
    } store_buffer_entry_t;

    localparam logic [1:0] DRAIN_IDLE  = 2'd0;
    localparam logic [1:0] DRAIN_POP   = 2'd1;
    localparam logic [1:0] DRAIN_LATCH = 2'd2;
    localparam logic [1:0] DRAIN_WRITE = 2'd3;

endpackage

// File: rtl/store_buffer_drain_if.sv
// Store-buffer read port plus data-memory write port used by the drain.
// master: drain side (pops entries, issues writes).
// slave:  store buffer / memory side.
interface store_buffer_drain_if;
    import data_memory_pkg::*;

    logic                st_buf_empty_i;
    logic                st_buf_pop_o;
    store_buffer_entry_t st_buf_packet_i;
    logic                mem_write_o;
    logic [31:0]         mem_address_o;
    logic [31:0]         mem_data_o;
    logic [3:0]          mem_byte_enable_o;
    logic                mem_done_i;

    modport master (
        input  st_buf_empty_i, st_buf_packet_i, mem_done_i,
        output st_buf_pop_o, mem_write_o, mem_address_o, mem_data_o,
               mem_byte_enable_o
    );

    modport slave (
        output st_buf_empty_i, st_buf_packet_i, mem_done_i,
        input  st_buf_pop_o, mem_write_o, mem_address_o, mem_data_o,
               mem_byte_enable_o
    );

endinterface

// File: rtl/store_lane_align.sv
// Combinational lane alignment for a sub-word access.
// Ports: offset_i (address[1:0]), data_i, width_i -> byte_enable_o,
//        aligned_data_o (value replicated across lanes), misaligned_o.
// Only the low address bits matter, so only those are taken.
module store_lane_align
    import data_memory_pkg::*;
(
    input  logic [1:0]   offset_i,
    input  logic [31:0]  data_i,
    input  store_width_t width_i,
    output logic [3:0]   byte_enable_o,
    output logic [31:0]  aligned_data_o,
    output logic         misaligned_o
);

    always_comb begin
        byte_enable_o  = 4'b0000;
        aligned_data_o = data_i;
        misaligned_o   = 1'b0;
        case (width_i)
            BYTE: begin
                byte_enable_o  = 4'b0001 << offset_i;
                aligned_data_o = {4{data_i[7:0]}};
            end
            HALF: begin
                byte_enable_o  = 4'b0011 << {offset_i[1], 1'b0};
                aligned_data_o = {2{data_i[15:0]}};
                misaligned_o   = offset_i[0];
            end
            WORD: begin
                byte_enable_o = 4'b1111;
                misaligned_o  = |offset_i;
            end
            // Unencoded width: treat as unusable so the entry is discarded.
            default: misaligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_buffer_drain.sv
// Drains the store buffer one entry at a time onto the data-memory write
// port, with alignment checking, a per-transaction timeout and yielding
// to pending load misses.
// Ports: clk_i, rst_n_i (async active-low); bus (store-buffer pop port and
//        memory write port); load_pending_i; misaligned_o / timeout_o
//        (one-cycle pulses); idle_o (combinational, for fences).
module store_buffer_drain
    import data_memory_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    store_buffer_drain_if.master bus,
    input  logic                 load_pending_i,
    output logic                 misaligned_o,
    output logic                 timeout_o,
    output logic                 idle_o
);

    localparam int unsigned         CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop_q, pop_d;
    logic             write_q, write_d;
    logic             mis_q, mis_d;
    logic             to_q, to_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [3:0]       be_q, be_d;

    logic [3:0]       al_be;
    logic [31:0]      al_data;
    logic             al_mis;

    store_lane_align u_align (
        .offset_i       (bus.st_buf_packet_i.address[1:0]),
        .data_i         (bus.st_buf_packet_i.data),
        .width_i        (bus.st_buf_packet_i.width),
        .byte_enable_o  (al_be),
        .aligned_data_o (al_data),
        .misaligned_o   (al_mis)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mis_d   = 1'b0;
        to_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        case (state_q)
            DRAIN_IDLE: begin
                cnt_d = '0;
                if (!bus.st_buf_empty_i && !load_pending_i) begin
                    state_d = DRAIN_POP;
                end
            end
            DRAIN_POP: begin
                state_d = DRAIN_LATCH;
            end
            DRAIN_LATCH: begin
                // Entry is valid this cycle; capture it whether or not it is usable.
                addr_d = {bus.st_buf_packet_i.address[31:2], 2'b00};
                data_d = al_data;
                be_d   = al_be;
                cnt_d  = '0;
                if (al_mis) begin
                    mis_d   = 1'b1;
                    state_d = DRAIN_IDLE;
                end else begin
                    state_d = DRAIN_WRITE;
                end
            end
            DRAIN_WRITE: begin
                // Completion takes priority over a coinciding timeout.
                if (bus.mem_done_i) begin
                    cnt_d   = '0;
                    state_d = DRAIN_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    to_d    = 1'b1;
                    state_d = DRAIN_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = DRAIN_IDLE;
            end
        endcase
        pop_d   = (state_d == DRAIN_POP);
        write_d = (state_d == DRAIN_WRITE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= DRAIN_IDLE;
            cnt_q   <= '0;
            pop_q   <= 1'b0;
            write_q <= 1'b0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pop_q   <= pop_d;
            write_q <= write_d;
            mis_q   <= mis_d;
            to_q    <= to_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
        end
    end

    assign bus.st_buf_pop_o      = pop_q;
    assign bus.mem_write_o       = write_q;
    assign bus.mem_address_o     = addr_q;
    assign bus.mem_data_o        = data_q;
    assign bus.mem_byte_enable_o = be_q;
    assign misaligned_o          = mis_q;
    assign timeout_o             = to_q;
    assign idle_o                = (state_q == DRAIN_IDLE) && bus.st_buf_empty_i;

endmodule

// File: tb/tb_store_buffer_drain.sv
// Scoreboard bench for store_buffer_drain: directed scenarios followed by
// randomized entries, checked against a byte-level reference model.
module tb_store_buffer_drain;
    import data_memory_pkg::*;

    localparam int unsigned T_CYC = 4;
    localparam int K_WRITE   = 0;
    localparam int K_MIS     = 1;
    localparam int K_TIMEOUT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_pending = 1'b0;
    logic misaligned, timeout, idle;

    store_buffer_drain_if bus_if ();

    store_buffer_drain #(.TIMEOUT_CYCLES(T_CYC)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .bus            (bus_if),
        .load_pending_i (load_pending),
        .misaligned_o   (misaligned),
        .timeout_o      (timeout),
        .idle_o         (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        int          len;
        int          lat;
    } exp_t;

    exp_t                exp_q[$];
    store_buffer_entry_t sb_q[$];
    int                  n_checks = 0;
    int                  n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: byte-granular view of a store of `size` bytes at `addr`.
    function automatic exp_t model(input logic [31:0] addr, input logic [31:0] data,
                                   input store_width_t w, input int lat);
        exp_t e;
        int size;
        int off;
        size = (w == BYTE) ? 1 : (w == HALF) ? 2 : 4;
        off  = int'(addr % 32'd4);
        e.addr = addr & ~32'h3;
        e.lat  = lat;
        e.data = '0;
        e.be   = '0;
        if ((addr % 32'(size)) != 32'd0) begin
            e.kind = K_MIS;
            e.len  = 0;
        end else begin
            e.be = 4'(((1 << size) - 1) << off);
            for (int i = 0; i < 4; i++) begin
                e.data[8*i +: 8] = data[8*(i % size) +: 8];
            end
            e.kind = (lat <= int'(T_CYC)) ? K_WRITE : K_TIMEOUT;
            e.len  = (lat <= int'(T_CYC)) ? lat : int'(T_CYC);
        end
        return e;
    endfunction

    task automatic push_entry(input logic [31:0] addr, input logic [31:0] data,
                              input store_width_t w, input int lat);
        store_buffer_entry_t ent;
        ent.address = addr;
        ent.data    = data;
        ent.width   = w;
        sb_q.push_back(ent);
        exp_q.push_back(model(addr, data, w, lat));
    endtask

    // Store buffer model: registered empty flag, entry valid the cycle after pop.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_if.st_buf_packet_i <= '0;
            bus_if.st_buf_empty_i  <= (sb_q.size() == 0);
        end else begin
            if (bus_if.st_buf_pop_o) begin
                chk("pop_when_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) bus_if.st_buf_packet_i <= sb_q.pop_front();
            end
            bus_if.st_buf_empty_i <= (sb_q.size() == 0);
        end
    end

    // Monitor + memory responder: checks every write cycle and each pulse.
    exp_t cur;
    exp_t cur_m;
    int   wcycles = 0;
    logic prev_pop = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            wcycles = 0;
            prev_pop = 1'b0;
            bus_if.mem_done_i = 1'b0;
        end else begin
            if (bus_if.st_buf_pop_o) chk("no_back_to_back_pop", 32'(prev_pop), 32'd0);
            prev_pop = bus_if.st_buf_pop_o;
            if (bus_if.mem_write_o) begin
                if (wcycles == 0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 32'd1, 32'd0);
                        cur.kind = K_WRITE; cur.lat = 1; cur.len = 1;
                        cur.addr = bus_if.mem_address_o; cur.data = bus_if.mem_data_o;
                        cur.be = bus_if.mem_byte_enable_o;
                    end else begin
                        cur = exp_q.pop_front();
                        chk("write_not_misaligned", 32'(cur.kind == K_MIS), 32'd0);
                    end
                end
                chk("write_addr", bus_if.mem_address_o, cur.addr);
                chk("write_data", bus_if.mem_data_o, cur.data);
                chk("write_be", 32'(bus_if.mem_byte_enable_o), 32'(cur.be));
                wcycles++;
                bus_if.mem_done_i = (wcycles == cur.lat);
            end else begin
                bus_if.mem_done_i = 1'b0;
                if (wcycles > 0) begin
                    chk("write_len", 32'(wcycles), 32'(cur.len));
                    chk("timeout_pulse", 32'(timeout), 32'(cur.kind == K_TIMEOUT));
                    wcycles = 0;
                end else if (timeout) begin
                    chk("spurious_timeout", 32'd1, 32'd0);
                end
            end
            if (misaligned) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_misaligned", 32'd1, 32'd0);
                end else begin
                    cur_m = exp_q.pop_front();
                    chk("misaligned_expected", 32'(cur_m.kind), 32'(K_MIS));
                end
            end
        end
    end

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && sb_q.size() == 0 && idle && !bus_if.mem_write_o)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_write(input string name, input int budget);
        int n = 0;
        while (!bus_if.mem_write_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    initial begin
        bit found;
        int gap;
        logic [31:0] a;

        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Reset state with empty buffer.
        @(negedge clk);
        chk("rst_addr", bus_if.mem_address_o, 32'd0);
        chk("rst_data", bus_if.mem_data_o, 32'd0);
        chk("rst_be", 32'(bus_if.mem_byte_enable_o), 32'd0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        for (int i = 0; i < 20; i++) begin
            chk("empty_idle", 32'(idle), 32'd1);
            chk("empty_no_pop", 32'(bus_if.st_buf_pop_o), 32'd0);
            chk("empty_no_write", 32'(bus_if.mem_write_o), 32'd0);
            @(negedge clk);
        end

        // HALF at 0x1000_0006, done on the third write cycle.
        push_entry(32'h1000_0006, 32'hAABB_CCDD, HALF, 3);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (bus_if.st_buf_pop_o) found = 1'b1;
        end
        chk("t2_pop_seen", 32'(found), 32'd1);
        @(negedge clk);
        chk("t2_no_write_t1", 32'(bus_if.mem_write_o), 32'd0);
        @(negedge clk);
        chk("t2_write_t2", 32'(bus_if.mem_write_o), 32'd1);
        chk("t2_addr", bus_if.mem_address_o, 32'h1000_0004);
        chk("t2_be", 32'(bus_if.mem_byte_enable_o), 32'hC);
        chk("t2_data", bus_if.mem_data_o, 32'hCCDD_CCDD);
        @(negedge clk);
        chk("t2_write_t3", 32'(bus_if.mem_write_o), 32'd1);
        @(negedge clk);
        chk("t2_write_t4", 32'(bus_if.mem_write_o), 32'd1);
        @(negedge clk);
        chk("t2_write_done_t5", 32'(bus_if.mem_write_o), 32'd0);
        chk("t2_idle_t5", 32'(idle), 32'd1);
        wait_drain("t2_drain", 50);

        // BYTE lane placement, then a misaligned WORD.
        push_entry(32'h0000_0003, 32'h0000_005A, BYTE, 2);
        wait_write("t3_byte_write", 30);
        chk("t3_byte_be", 32'(bus_if.mem_byte_enable_o), 32'h8);
        chk("t3_byte_data", bus_if.mem_data_o, 32'h5A5A_5A5A);
        wait_drain("t3_byte_drain", 50);
        push_entry(32'h0000_0002, 32'h1234_5678, WORD, 2);
        wait_drain("t3_mis_drain", 50);

        // load_pending blocks a new drain but not one in progress.
        load_pending = 1'b1;
        push_entry(32'h0000_0040, 32'hDEAD_BEEF, WORD, 3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_no_pop_while_load", 32'(bus_if.st_buf_pop_o), 32'd0);
        end
        load_pending = 1'b0;
        @(negedge clk);
        chk("t4_pop_after_release", 32'(bus_if.st_buf_pop_o), 32'd1);
        wait_write("t4_write", 30);
        load_pending = 1'b1;
        wait_drain("t4_drain", 50);
        load_pending = 1'b0;

        // Timeout path, then done exactly on the last allowed cycle.
        push_entry(32'h0000_0100, 32'h0BAD_F00D, WORD, 99);
        wait_drain("t5_timeout_drain", 50);
        push_entry(32'h0000_0104, 32'h600D_F00D, WORD, int'(T_CYC));
        wait_drain("t5_late_done_drain", 50);

        // Asynchronous reset in the middle of a write.
        push_entry(32'h0000_0200, 32'hCAFE_0001, WORD, 99);
        wait_write("t6_write", 30);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_write_dropped", 32'(bus_if.mem_write_o), 32'd0);
        chk("t6_be_cleared", 32'(bus_if.mem_byte_enable_o), 32'd0);
        chk("t6_idle", 32'(idle), 32'd1);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        push_entry(32'h0000_0300, 32'h1357_9BDF, HALF, 2);
        wait_drain("t6_after_reset_drain", 50);

        // Randomized entries with random gaps and load_pending noise.
        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            a[1:0] = 2'($urandom_range(0, 3));
            push_entry(a, $urandom, store_width_t'($urandom_range(0, 2)),
                       int'($urandom_range(1, 6)));
            gap = int'($urandom_range(0, 6));
            for (int g = 0; g < gap; g++) begin
                load_pending = ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
            load_pending = 1'b0;
        end
        wait_drain("random_drain", 3000);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
